// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle between the UART controller (master) and uart_tx (slave).
interface uart_tx_if;
    logic       tx_start;
    logic       tx_valid;
    logic [8:0] tx_data;
    logic       data_9b;
    logic       parity_en;
    logic       parity_odd;
    logic       two_stop;
    logic       tx_ready;
    logic       tx_idle;
    logic       tx_done;
    logic       txd;

    modport master (
        output tx_start, tx_valid, tx_data, data_9b, parity_en, parity_odd, two_stop,
        input  tx_ready, tx_idle, tx_done, txd
    );

    modport slave (
        input  tx_start, tx_valid, tx_data, data_9b, parity_en, parity_odd, two_stop,
        output tx_ready, tx_idle, tx_done, txd
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8/9 data bits LSB first, optional parity, 1/2 stop bits.
// Parity generator and PARITY state are built only when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input logic      clk,
    input logic      rst,
    uart_tx_if.slave bus
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       bit_idx_q;
    logic [8:0]       data_q;
    logic             data_9b_q;
    logic             two_stop_q;
    logic             stop2_q;
    logic             txd_q;
    logic             done_q;

    logic             accept;
    logic             cnt_end;
    logic             last_bit;
    logic [3:0]       bit_nxt;

    assign accept   = bus.tx_start & bus.tx_valid & (state_q == StIdle);
    assign cnt_end  = (cnt_q == CNT_LAST);
    assign last_bit = (bit_idx_q == (data_9b_q ? 4'd8 : 4'd7));
    assign bit_nxt  = bit_idx_q + 4'd1;

`ifdef UART_TX_PARITY_EN
    logic       par_en_q;
    logic       par_bit_q;
    logic [8:0] par_mask;
    logic       par_calc;

    // Bit 8 only contributes to parity in 9-bit mode.
    assign par_mask = bus.data_9b ? 9'h1FF : 9'h0FF;
    assign par_calc = (^(bus.tx_data & par_mask)) ^ bus.parity_odd;
`else
    logic unused_parity;
    assign unused_parity = bus.parity_en ^ bus.parity_odd;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            data_9b_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle) begin
                cnt_q <= cnt_end ? '0 : cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q    <= StStart;
                        cnt_q      <= '0;
                        bit_idx_q  <= '0;
                        stop2_q    <= 1'b0;
                        data_q     <= bus.tx_data;
                        data_9b_q  <= bus.data_9b;
                        two_stop_q <= bus.two_stop;
                        txd_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_en_q   <= bus.parity_en;
                        par_bit_q  <= par_calc;
`endif
                    end
                end

                StStart: begin
                    if (cnt_end) begin
                        state_q   <= StData;
                        bit_idx_q <= '0;
                        txd_q     <= data_q[0];
                    end
                end

                StData: begin
                    if (cnt_end) begin
                        if (!last_bit) begin
                            bit_idx_q <= bit_nxt;
                            txd_q     <= data_q[bit_nxt];
                        end else
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_q <= StParity;
                            txd_q   <= par_bit_q;
                        end else
`endif
                        begin
                            state_q <= StStop;
                            txd_q   <= 1'b1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (cnt_end) begin
                        state_q <= StStop;
                        txd_q   <= 1'b1;
                    end
                end
`endif

                StStop: begin
                    if (cnt_end) begin
                        // Second stop bit is just another pass through this state.
                        if (two_stop_q && !stop2_q) begin
                            stop2_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx_ready = (state_q == StIdle);
    assign bus.tx_idle  = (state_q == StIdle);
    assign bus.tx_done  = done_q;
    assign bus.txd      = txd_q;

    a_done_in_idle: assert property (@(posedge clk) disable iff (rst)
        done_q |-> (state_q == StIdle));
    a_idle_mark: assert property (@(posedge clk) disable iff (rst)
        (state_q == StIdle) |-> txd_q);
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4; parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected line waveform: frame bit i held for CPB samples starting at sample 'at'.
    function automatic logic [127:0] put_frame(input logic [127:0] base, input logic [15:0] frame,
                                               input int nbits, input int at);
        logic [127:0] w;
        w = base;
        for (int k = 0; k < nbits * CPB; k++) w[at + k] = frame[k / CPB];
        return w;
    endfunction

    task automatic send(input logic [8:0] d, input logic d9, input logic pe, input logic po,
                        input logic ts);
        bus.tx_data    = d;
        bus.data_9b    = d9;
        bus.parity_en  = pe;
        bus.parity_odd = po;
        bus.two_stop   = ts;
        bus.tx_start   = 1'b1;
        bus.tx_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_start = 1'b0;
        bus.tx_valid = 1'b0;
    endtask

    // Sample k is taken 1 time unit after accept edge + k; optionally pulse start at poke_at.
    task automatic capture(input int n, input int poke_at, output logic [127:0] got,
                           output int first_done, output int last_done, output int n_done);
        got        = '1;
        first_done = -1;
        last_done  = -1;
        n_done     = 0;
        for (int k = 0; k < n; k++) begin
            got[k] = bus.txd;
            if (bus.tx_done === 1'b1) begin
                if (first_done < 0) first_done = k;
                last_done = k;
                n_done++;
            end
            if (k == poke_at) begin
                bus.tx_start = 1'b1;
                bus.tx_valid = 1'b1;
            end
            if (k == poke_at + 2) begin
                bus.tx_start = 1'b0;
                bus.tx_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.txd !== 1'b1) begin errors++; $display("FAIL rst_txd: got %b want 1", bus.txd); end
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.tx_ready); end
        checks++; if (bus.tx_idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b want 1", bus.tx_idle); end
        checks++; if (bus.tx_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.tx_done); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", bus.tx_ready); end
        checks++; if (bus.txd !== 1'b1) begin errors++; $display("FAIL post_rst_txd: got %b want 1", bus.txd); end
    endtask

    task automatic test_8n1();
        logic [127:0] got, exp;
        int fd, ld, nd;
        send(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL 8n1_busy_ready: got %b want 0", bus.tx_ready); end
        checks++; if (bus.tx_idle !== 1'b0) begin errors++; $display("FAIL 8n1_busy_idle: got %b want 0", bus.tx_idle); end
        capture(60, -1, got, fd, ld, nd);
        exp = put_frame('1, 16'({1'b1, 8'hA5, 1'b0}), 10, 0);
        checks++; if (got !== exp) begin errors++; $display("FAIL 8n1_wave: got %h want %h", got, exp); end
        checks++; if (fd !== 40) begin errors++; $display("FAIL 8n1_done_at: got %0d want 40", fd); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL 8n1_done_cnt: got %0d want 1", nd); end
        checks++; if (bus.tx_ready !== 1'b1 || bus.tx_idle !== 1'b1) begin
            errors++; $display("FAIL 8n1_ready_after: got %b%b want 11", bus.tx_ready, bus.tx_idle);
        end
    endtask

    task automatic test_9bit_parity();
        logic [127:0] got, exp;
        int fd, ld, nd, len;
        send(9'h1FF, 1'b1, 1'b1, 1'b0, 1'b0);
        capture(60, -1, got, fd, ld, nd);
`ifdef UART_TX_PARITY_EN
        len = 12;
        exp = put_frame('1, 16'({1'b1, 1'b1, 9'h1FF, 1'b0}), 12, 0);
`else
        len = 11;
        exp = put_frame('1, 16'({1'b1, 9'h1FF, 1'b0}), 11, 0);
`endif
        checks++; if (got !== exp) begin errors++; $display("FAIL 9b_wave: got %h want %h", got, exp); end
        checks++; if (fd !== len * CPB) begin errors++; $display("FAIL 9b_done_at: got %0d want %0d", fd, len * CPB); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL 9b_done_cnt: got %0d want 1", nd); end
    endtask

    // Bit 8 set but 8-bit mode: must be neither sent nor counted in parity.
    task automatic test_parity_odd();
        logic [127:0] got, exp;
        int fd, ld, nd, len;
        send(9'h101, 1'b0, 1'b1, 1'b1, 1'b0);
        capture(60, -1, got, fd, ld, nd);
`ifdef UART_TX_PARITY_EN
        len = 11;
        exp = put_frame('1, 16'({1'b1, 1'b0, 8'h01, 1'b0}), 11, 0);
`else
        len = 10;
        exp = put_frame('1, 16'({1'b1, 8'h01, 1'b0}), 10, 0);
`endif
        checks++; if (got !== exp) begin errors++; $display("FAIL odd_wave: got %h want %h", got, exp); end
        checks++; if (fd !== len * CPB) begin errors++; $display("FAIL odd_done_at: got %0d want %0d", fd, len * CPB); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL odd_done_cnt: got %0d want 1", nd); end
    endtask

    task automatic test_even_two_stop();
        logic [127:0] got, exp;
        int fd, ld, nd, len;
        send(9'h001, 1'b0, 1'b1, 1'b0, 1'b1);
        capture(60, -1, got, fd, ld, nd);
`ifdef UART_TX_PARITY_EN
        len = 12;
        exp = put_frame('1, 16'({1'b1, 1'b1, 1'b1, 8'h01, 1'b0}), 12, 0);
`else
        len = 11;
        exp = put_frame('1, 16'({1'b1, 1'b1, 8'h01, 1'b0}), 11, 0);
`endif
        checks++; if (got !== exp) begin errors++; $display("FAIL 2stop_wave: got %h want %h", got, exp); end
        checks++; if (fd !== len * CPB) begin errors++; $display("FAIL 2stop_done_at: got %0d want %0d", fd, len * CPB); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL 2stop_done_cnt: got %0d want 1", nd); end
    endtask

    task automatic test_parity_ignored();
        logic [127:0] got, exp;
        int fd, ld, nd, len;
        send(9'h0A5, 1'b0, 1'b1, 1'b0, 1'b0);
        capture(60, -1, got, fd, ld, nd);
`ifdef UART_TX_PARITY_EN
        len = 11;
        exp = put_frame('1, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 0);
`else
        len = 10;
        exp = put_frame('1, 16'({1'b1, 8'hA5, 1'b0}), 10, 0);
`endif
        checks++; if (got !== exp) begin errors++; $display("FAIL pen_wave: got %h want %h", got, exp); end
        checks++; if (fd !== len * CPB) begin errors++; $display("FAIL pen_done_at: got %0d want %0d", fd, len * CPB); end
    endtask

    task automatic test_busy_ignore();
        logic [127:0] got, exp;
        int fd, ld, nd;
        send(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.tx_data    = 9'h055;
        bus.data_9b    = 1'b1;
        bus.two_stop   = 1'b1;
        bus.parity_en  = 1'b1;
        bus.parity_odd = 1'b1;
        capture(60, 12, got, fd, ld, nd);
        exp = put_frame('1, 16'({1'b1, 8'hA5, 1'b0}), 10, 0);
        checks++; if (got !== exp) begin errors++; $display("FAIL busy_wave: got %h want %h", got, exp); end
        checks++; if (nd !== 1 || fd !== 40) begin
            errors++; $display("FAIL busy_done: got cnt %0d at %0d want 1 at 40", nd, fd);
        end
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL busy_ready_after: got %b want 1", bus.tx_ready); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] got, exp;
        int fd, ld, nd, bad;
        send(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (17) begin @(posedge clk); #1; end
        checks++; if (bus.txd !== 1'b0) begin errors++; $display("FAIL rmid_bit3: got %b want 0", bus.txd); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.txd !== 1'b1) begin errors++; $display("FAIL rmid_txd: got %b want 1", bus.txd); end
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", bus.tx_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.tx_done !== 1'b0 || bus.txd !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_quiet: got %0d bad cycles want 0", bad); end
        send(9'h03C, 1'b0, 1'b0, 1'b0, 1'b0);
        capture(50, -1, got, fd, ld, nd);
        exp = put_frame('1, 16'({1'b1, 8'h3C, 1'b0}), 10, 0);
        checks++; if (got !== exp) begin errors++; $display("FAIL rmid_clean_wave: got %h want %h", got, exp); end
        checks++; if (fd !== 40 || nd !== 1) begin
            errors++; $display("FAIL rmid_clean_done: got cnt %0d at %0d want 1 at 40", nd, fd);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] got, exp;
        int fd, ld, nd;
        send(9'h00F, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.tx_data = 9'h081;
        capture(96, 40, got, fd, ld, nd);
        exp = put_frame('1, 16'({1'b1, 8'h0F, 1'b0}), 10, 0);
        exp = put_frame(exp, 16'({1'b1, 8'h81, 1'b0}), 10, 41);
        checks++; if (got !== exp) begin errors++; $display("FAIL b2b_wave: got %h want %h", got, exp); end
        checks++; if (fd !== 40) begin errors++; $display("FAIL b2b_first_done: got %0d want 40", fd); end
        checks++; if (ld !== 81) begin errors++; $display("FAIL b2b_last_done: got %0d want 81", ld); end
        checks++; if (nd !== 2) begin errors++; $display("FAIL b2b_done_cnt: got %0d want 2", nd); end
    endtask

    initial begin
        bus.tx_start   = 1'b0;
        bus.tx_valid   = 1'b0;
        bus.tx_data    = '0;
        bus.data_9b    = 1'b0;
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b0;
        bus.two_stop   = 1'b0;
        test_reset();
        test_8n1();
        test_9bit_parity();
        test_parity_odd();
        test_even_two_stop();
        test_parity_ignored();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
